muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operands from EX and runs a 32-iteration shift-add multiply or restoring divide. While busy it raises `stallreq` into the stall controller. It delivers the {hi, lo} result, which EX forwards toward the HI/LO registers.

## Interface
Parameters:
- `ITER`, 32: iterations per operation. Equals operand width; not intended to be overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  EX holds a mul/div instruction. Level signal, held while EX is stalled.
- `op_i`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `opdata1_i`  in  32  rs value, already forwarded (dividend / multiplicand).
- `opdata2_i`  in  32  rt value, already forwarded (divisor / multiplier).
- `cancel_i`  in  1  flush; abort the current operation.
- `stall_i`  in  1  EX is frozen by another stall source this cycle.
- `stallreq`  out  1  request to freeze IF..EX.
- `ready_o`  out  1  result valid.
- `hi_o`  out  32  MULT: product[63:32]; DIV: remainder.
- `lo_o`  out  32  MULT: product[31:0]; DIV: quotient.
- `div_zero_o`  out  1  DIV/DIVU with divisor 0; valid with `ready_o`.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset sets IDLE, cnt = 0, all datapath registers 0, all outputs 0.
- IDLE, `start_i & !cancel_i`:
  - Latch `op_i`. For signed ops, latch |opdata1| and |opdata2| (two's-complement negate if bit 31 is set); for unsigned ops latch the raw values. Also latch sign1 and sign2 (forced 0 for unsigned).
  - DIV/DIVU with opdata2 == 0: go to DONE. Result is hi = lo = 0 and `div_zero_o` = 1.
  - Otherwise set cnt = 0 and go to RUN.
- RUN, multiply, each cycle:
  - If multiplier bit[cnt] is set, add multiplicand << cnt into the 64-bit accumulator.
- RUN, divide, each cycle:
  - Shift {rem, quo} left 1.
  - If rem ≥ divisor: rem -= divisor and set quo[0] = 1.
- RUN advances cnt each cycle. At cnt == ITER-1, go to DONE.
- Sign fixup on the transition into DONE, registered:
  - Product is negated when sign1 ^ sign2.
  - Quotient is negated when sign1 ^ sign2.
  - Remainder takes the sign of the dividend (negated when sign1).
  - Unsigned ops get no fixup.
- DONE:
  - `ready_o` = 1, `hi_o`/`lo_o`/`div_zero_o` hold the result.
  - `!stall_i` → IDLE.
  - `stall_i` → stay in DONE with the result held. The still-asserted `start_i` must not restart the operation.
- `stallreq` = (IDLE & `start_i` & !`cancel_i` & !div_zero_case) | RUN. It is deasserted in DONE.
- `cancel_i` in any state → IDLE next cycle, with no `ready_o` pulse. `cancel_i` has priority over `start_i` and over RUN completion.
- `hi_o`/`lo_o` keep their last value outside DONE. Consumers must qualify them with `ready_o`.
- All arithmetic wraps modulo 2^32 / 2^64. Negating 0x80000000 yields 0x80000000, which is treated as an unsigned magnitude of 2^31.

## Timing
- Normal op: issue in cycle 0, RUN in cycles 1..32, DONE (`ready_o` = 1) in cycle 33.
  - `stallreq` is high in cycles 0..32 and low in cycle 33, so EX advances with the result in that cycle.
- Divide by zero: cycle 0 issue, cycle 1 DONE, `stallreq` never asserted.
- DONE lasts exactly 1 cycle when `stall_i` = 0. Otherwise it lasts until the first cycle with `stall_i` = 0, inclusive.
- A new op can be accepted in the cycle after DONE exits. There is no back-to-back acceptance in DONE.
- `rst` mid-RUN or in DONE → IDLE on the next edge. Outputs are 0 after that edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `ready_o` at cycle 33, hi = 0xFFFFFFFE, lo = 0x00000001. `stallreq` is high for exactly cycles 0..32.
- MULT −3 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 7 → lo = 14, hi = 2.
- DIVU 100 / 0 → `ready_o` at cycle 1, `div_zero_o` = 1, hi = lo = 0, `stallreq` stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0 (wrap, no trap).
- Control-path checks:
  - `cancel_i` at RUN cycle 10 → IDLE next cycle, `stallreq` = 0, no `ready_o`.
  - `stall_i` high for 3 cycles in DONE with `start_i` held → `ready_o` high for 4 cycles, result stable, no restart.
  - `rst` at RUN cycle 20 → all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32-cycle multiply/divide sequencer for the EX stage.
// Runs shift-add multiply (MULT/MULTU) or restoring divide (DIV/DIVU) on
// operand magnitudes, applies the sign fixup on entry to DONE, and holds
// the pipeline through stallreq while busy.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i, op_i     issue request (level) and operation select
//   opdata1_i/2_i     rs / rt operands
//   cancel_i          flush, aborts any operation
//   stall_i           EX frozen by another source (holds DONE)
//   stallreq          freeze request toward IF..EX (combinational)
//   ready_o           result valid
//   hi_o, lo_o        {hi, lo} result
//   div_zero_o        divide by zero flag, valid with ready_o
module muldiv_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        cancel_i,
    input  logic        stall_i,
    output logic        stallreq,
    output logic        ready_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            sign1;
    logic            sign2;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    // Multiply: 64-bit product accumulator. Divide: {rem, quo}.
    logic [2*W-1:0]  acc;

    logic            div_zero_case;
    logic            neg1;
    logic            neg2;
    logic [W-1:0]    mag1;
    logic [W-1:0]    mag2;
    logic [2*W-1:0]  addend;
    logic [2*W-1:0]  acc_mul;
    logic [W:0]      rem_sh;
    logic [W:0]      rem_sub;
    logic            rem_ge;
    logic [2*W-1:0]  acc_div;
    logic [2*W-1:0]  acc_next;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic [W-1:0]    res_hi;
    logic [W-1:0]    res_lo;

    // Operand magnitudes, one iteration step, and the final sign fixup.
    always_comb begin
        div_zero_case = op_i[1] && (opdata2_i == '0);
        neg1          = op_i[0] && opdata1_i[W-1];
        neg2          = op_i[0] && opdata2_i[W-1];
        mag1          = neg1 ? (~opdata1_i + W'(1)) : opdata1_i;
        mag2          = neg2 ? (~opdata2_i + W'(1)) : opdata2_i;

        addend  = {{W{1'b0}}, opa} << cnt;
        acc_mul = opb[cnt] ? (acc + addend) : acc;

        // Remainder is kept one bit wider so the compare never overflows.
        rem_sh  = {acc[2*W-1:W], acc[W-1]};
        rem_ge  = (rem_sh >= {1'b0, opb});
        rem_sub = rem_sh - {1'b0, opb};
        acc_div = {(rem_ge ? rem_sub[W-1:0] : rem_sh[W-1:0]), acc[W-2:0], rem_ge};

        acc_next = is_div ? acc_div : acc_mul;

        prod_fix = (sign1 ^ sign2) ? (~acc_next + (2*W)'(1)) : acc_next;
        quo_fix  = (sign1 ^ sign2) ? (~acc_next[W-1:0] + W'(1)) : acc_next[W-1:0];
        rem_fix  = sign1 ? (~acc_next[2*W-1:W] + W'(1)) : acc_next[2*W-1:W];

        res_hi = is_div ? rem_fix : prod_fix[2*W-1:W];
        res_lo = is_div ? quo_fix : prod_fix[W-1:0];

        stallreq = ((state == IDLE) && start_i && !cancel_i && !div_zero_case)
                   || (state == RUN);
    end

    // Sequencer FSM with registered datapath and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_div     <= 1'b0;
            sign1      <= 1'b0;
            sign2      <= 1'b0;
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            ready_o    <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            div_zero_o <= 1'b0;
        end else if (cancel_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        is_div <= op_i[1];
                        sign1  <= neg1;
                        sign2  <= neg2;
                        opa    <= mag1;
                        opb    <= mag2;
                        cnt    <= '0;
                        if (div_zero_case) begin
                            state      <= DONE;
                            ready_o    <= 1'b1;
                            div_zero_o <= 1'b1;
                            hi_o       <= '0;
                            lo_o       <= '0;
                        end else begin
                            state <= RUN;
                            acc   <= op_i[1] ? {{W{1'b0}}, mag1} : '0;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state      <= DONE;
                        ready_o    <= 1'b1;
                        div_zero_o <= 1'b0;
                        hi_o       <= res_hi;
                        lo_o       <= res_lo;
                    end
                end
                DONE: begin
                    // A held start_i is ignored here; acceptance resumes in IDLE.
                    if (!stall_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl with a
// result scoreboard (expected {hi, lo, div_zero} queued at issue time).
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        cancel_i;
    logic        stall_i;
    logic        stallreq;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    muldiv_ctrl #(.ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .cancel_i   (cancel_i),
        .stall_i    (stall_i),
        .stallreq   (stallreq),
        .ready_o    (ready_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi_o), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo_o), 64'(e.lo));
            chk({tag, "_dz"}, 64'(div_zero_o), 64'(e.dz));
        end
    endtask

    // Issue one op at the current cycle start, follow it to ready_o, then
    // release start_i once DONE has been left.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz);
        int   ready_at;
        int   bad_stall;
        int   lat;
        logic exp_sr;
        exp_t e;
        lat = edz ? 1 : 33;
        e.hi = eh; e.lo = el; e.dz = edz;
        sb.push_back(e);
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
        ready_at = -1;
        bad_stall = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            exp_sr = !edz && (k < 33);
            if (stallreq !== exp_sr) bad_stall++;
            if (ready_o === 1'b1) begin
                ready_at = k;
                pop_compare(tag);
                break;
            end
            next_cycle();
        end
        chk({tag, "_latency"}, 64'(ready_at), 64'(lat));
        chk({tag, "_stallreq_cycles_bad"}, 64'(bad_stall), 64'd0);
        next_cycle();
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after_done"}, 64'(ready_o), 64'd0);
        next_cycle();
    endtask

    initial begin
        int   ready_cnt;
        int   first_ready;
        int   bad;
        int   seen_ready;
        exp_t e;

        rst = 1'b1; start_i = 1'b0; op_i = 2'b00; opdata1_i = '0; opdata2_i = '0;
        cancel_i = 1'b0; stall_i = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_stallreq", 64'(stallreq), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_hi", 64'(hi_o), 64'd0);
        chk("reset_lo", 64'(lo_o), 64'd0);
        chk("reset_dz", 64'(div_zero_o), 64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'd0, 32'd0, 1'b1);
        run_op("div_minint", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // Cancel at RUN cycle 10: flush also removes the EX instruction.
        start_i = 1'b1; op_i = 2'b00; opdata1_i = 32'd5; opdata2_i = 32'd6;
        for (int k = 0; k < 10; k++) next_cycle();
        cancel_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        chk("cancel_stallreq_in_run", 64'(stallreq), 64'd1);
        next_cycle();
        cancel_i = 1'b0;
        @(negedge clk);
        chk("cancel_stallreq_next", 64'(stallreq), 64'd0);
        chk("cancel_ready_next", 64'(ready_o), 64'd0);
        seen_ready = 0;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            @(negedge clk);
            if (ready_o !== 1'b0) seen_ready++;
        end
        chk("cancel_no_ready", 64'(seen_ready), 64'd0);
        next_cycle();

        // stall_i held 3 cycles in DONE with start_i held: no restart.
        e.hi = 32'd2; e.lo = 32'd14; e.dz = 1'b0;
        sb.push_back(e);
        start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd100; opdata2_i = 32'd7;
        ready_cnt = 0; first_ready = -1; bad = 0;
        for (int k = 0; k <= 37; k++) begin
            if (k == 33) stall_i = 1'b1;
            if (k == 36) stall_i = 1'b0;
            if (k == 37) start_i = 1'b0;
            @(negedge clk);
            if (ready_o === 1'b1) begin
                ready_cnt++;
                if (first_ready < 0) begin
                    first_ready = k;
                    pop_compare("stall_done");
                end else if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
                    bad++;
                end
            end
            if (k >= 33 && stallreq !== 1'b0) bad++;
            next_cycle();
        end
        chk("stall_first_ready", 64'(first_ready), 64'd33);
        chk("stall_ready_cycles", 64'(ready_cnt), 64'd4);
        chk("stall_hold_bad", 64'(bad), 64'd0);

        // Reset at RUN cycle 20.
        start_i = 1'b1; op_i = 2'b00; opdata1_i = 32'd123; opdata2_i = 32'd456;
        for (int k = 0; k < 20; k++) next_cycle();
        rst = 1'b1; start_i = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_stallreq", 64'(stallreq), 64'd0);
        chk("rst_run_ready", 64'(ready_o), 64'd0);
        chk("rst_run_hi", 64'(hi_o), 64'd0);
        chk("rst_run_lo", 64'(lo_o), 64'd0);
        chk("rst_run_dz", 64'(div_zero_o), 64'd0);
        next_cycle();

        run_op("after_rst_multu", 2'b00, 32'd123, 32'd456, 32'd0, 32'd56088, 1'b0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
